// File: rtl/output_drain_scheduler_if.sv
// Result-stream bundle between the ODS producer/controller, the host port and the drain scheduler.
interface output_drain_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [31:0]           in_x;
  logic [31:0]           in_y;
  logic [31:0]           in_ch;
  logic                  clear;
  logic                  flush_req;
  logic                  stall;
  logic                  flush_done;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [31:0]           out_x;
  logic [31:0]           out_y;
  logic [31:0]           out_ch;
  logic [OCC_W-1:0]      occupancy;
  logic                  overflow;

  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, clear, flush_req, out_ready,
    output stall, flush_done, out_valid, out_data, out_x, out_y, out_ch, occupancy, overflow
  );

  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, clear, flush_req, out_ready,
    input  stall, flush_done, out_valid, out_data, out_x, out_y, out_ch, occupancy, overflow
  );
endinterface

// File: rtl/output_drain_scheduler.sv
// Tagged-result FIFO between the ODS stream and the host port, with almost-full stall
// and an end-of-layer flush sequence reporting completion via a one-cycle flush_done.
module output_drain_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 3
) (
  input  logic                    clk,
  input  logic                    arst_n_in,
  output_drain_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  r_overflow;
  logic                  r_flush_done;
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [31:0]           r_mem_x    [DEPTH];
  logic [31:0]           r_mem_y    [DEPTH];
  logic [31:0]           r_mem_ch   [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [OCC_W-1:0] w_occ_next;

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == OCC_W'(DEPTH));
  assign w_pop   = !w_empty && bus.out_ready;
  assign w_push  = bus.in_valid && (!w_full || w_pop);

  always_comb begin
    w_occ_next = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_next = r_occ + OCC_W'(1);
      2'b01:   w_occ_next = r_occ - OCC_W'(1);
      default: w_occ_next = r_occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push && !bus.clear) begin
      r_mem_data[r_wr_ptr] <= bus.in_data;
      r_mem_x[r_wr_ptr]    <= bus.in_x;
      r_mem_y[r_wr_ptr]    <= bus.in_y;
      r_mem_ch[r_wr_ptr]   <= bus.in_ch;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_overflow   <= 1'b0;
      r_flush_done <= 1'b0;
    end else if (bus.clear) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_overflow   <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      r_occ        <= w_occ_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (bus.in_valid && !w_push) r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          // An idle, empty buffer with nothing arriving completes the flush immediately.
          if (bus.flush_req) begin
            if (w_empty && !bus.in_valid) r_flush_done <= 1'b1;
            else                          r_state      <= FLUSH;
          end else if (w_push) begin
            r_state <= FILL;
          end
        end
        FILL: begin
          if (bus.flush_req)           r_state <= FLUSH;
          else if (w_occ_next == '0)   r_state <= IDLE;
        end
        FLUSH: begin
          if (w_empty && !bus.in_valid) begin
            r_state      <= IDLE;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall      = (r_occ >= OCC_W'(DEPTH - AF_MARGIN)) || (r_state == FLUSH);
  assign bus.flush_done = r_flush_done;
  assign bus.occupancy  = r_occ;
  assign bus.overflow   = r_overflow;
  assign bus.out_valid  = !w_empty;
  assign bus.out_data   = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign bus.out_x      = w_empty ? '0 : r_mem_x[r_rd_ptr];
  assign bus.out_y      = w_empty ? '0 : r_mem_y[r_rd_ptr];
  assign bus.out_ch     = w_empty ? '0 : r_mem_ch[r_rd_ptr];
endmodule

// File: tb/tb_output_drain_scheduler.sv
// Scoreboard bench: accepted pushes are queued by a bench-side occupancy model and compared on pop.
module tb_output_drain_scheduler;
  typedef struct packed {
    logic [31:0] d;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
  } item_t;

  logic clk;
  logic arst_n_in;
  int   n_checks;
  int   n_errors;
  int   m_occ;
  bit   m_ovf;
  item_t q[$];

  output_drain_scheduler_if #(.DATA_WIDTH(32), .DEPTH(8)) bus ();

  output_drain_scheduler #(.DATA_WIDTH(32), .DEPTH(8), .AF_MARGIN(3)) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input bit v, input logic [31:0] d, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ch);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_ch    = ch;
  endtask

  // One clock: update the bench model from the current inputs, capture head on pop.
  task automatic step(output bit popped, output item_t got, output item_t exp);
    bit pop;
    bit pu;
    popped = 1'b0;
    got    = '0;
    exp    = '0;
    pop    = (m_occ != 0) && bus.out_ready;
    if (bus.clear) begin
      q.delete();
      m_occ = 0;
      m_ovf = 1'b0;
    end else begin
      pu = bus.in_valid && ((m_occ < 8) || pop);
      if (pop) begin
        popped = 1'b1;
        got    = {bus.out_data, bus.out_x, bus.out_y, bus.out_ch};
        exp    = q.pop_front();
      end
      if (pu) q.push_back({bus.in_data, bus.in_x, bus.in_y, bus.in_ch});
      if (bus.in_valid && !pu) m_ovf = 1'b1;
      m_occ = m_occ + int'(pu) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n_in     = 1'b0;
    bus.clear     = 1'b0;
    bus.flush_req = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    #3;
    n_checks++;
    if ({bus.out_valid, bus.stall, bus.flush_done, bus.overflow, bus.occupancy} !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_flags: got v=%b st=%b fd=%b ov=%b occ=%0d, want all 0",
               bus.out_valid, bus.stall, bus.flush_done, bus.overflow, bus.occupancy);
    end
    n_checks++;
    if ({bus.out_data, bus.out_x, bus.out_y, bus.out_ch} !== 128'h0) begin
      n_errors++;
      $display("FAIL reset_outs: got %h, want 0", {bus.out_data, bus.out_x, bus.out_y, bus.out_ch});
    end
    #9 arst_n_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit p;
    item_t g, e;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, $urandom, 32'd5, 32'd7, i);
      step(p, g, e);
      if (p) begin
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL basic_pop: got %h want %h", g, e); end
      end
    end
    drive(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 20 && m_occ != 0; i++) begin
      step(p, g, e);
      if (p) begin
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL basic_pop: got %h want %h", g, e); end
      end
    end
    n_checks++;
    if (bus.occupancy !== 4'd0 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_empty: got occ=%0d v=%b, want occ=0 v=0", bus.occupancy, bus.out_valid);
    end
  endtask

  task automatic test_full_overflow();
    bit p;
    item_t g, e;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, $urandom, i, 32'd100 + i, 32'd3);
      step(p, g, e);
      n_checks++;
      if (bus.stall !== (i >= 4)) begin
        n_errors++;
        $display("FAIL full_stall push%0d: got %b want %b", i + 1, bus.stall, (i >= 4));
      end
    end
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.occupancy !== 4'd8) begin
      n_errors++;
      $display("FAIL full_drop: got ov=%b occ=%0d, want ov=1 occ=8", bus.overflow, bus.occupancy);
    end
    drive(1'b0, '0, '0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(p, g, e);
      n_checks++;
      if (!p || g !== e) begin n_errors++; $display("FAIL full_drain%0d: got %h want %h", i, g, e); end
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL full_after: got v=%b ov=%b, want v=0 ov=1", bus.out_valid, bus.overflow);
    end
    bus.clear = 1'b1;
    step(p, g, e);
    bus.clear = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_clear: got %b want 0", bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    bit p;
    item_t g, e;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, $urandom, 32'd200 + i, 32'd1, 32'd2);
      step(p, g, e);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, $urandom, 32'd300 + i, 32'd1, 32'd2);
      step(p, g, e);
      n_checks++;
      if (!p || g !== e) begin n_errors++; $display("FAIL b2b_pop%0d: got %h want %h", i, g, e); end
      n_checks++;
      if (bus.occupancy !== 4'd8 || bus.overflow !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_occ%0d: got occ=%0d ov=%b, want occ=8 ov=0", i, bus.occupancy, bus.overflow);
      end
    end
    drive(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 20 && m_occ != 0; i++) begin
      step(p, g, e);
      if (p) begin
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL b2b_drain: got %h want %h", g, e); end
      end
    end
    n_checks++;
    if (bus.occupancy !== 4'd0) begin
      n_errors++;
      $display("FAIL b2b_empty: got occ=%0d want 0", bus.occupancy);
    end
  endtask

  task automatic test_flush();
    bit p;
    item_t g, e;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 32'd9, 32'd9, i);
      step(p, g, e);
    end
    drive(1'b0, '0, '0, '0, '0);
    bus.flush_req = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(p, g, e);
      bus.flush_req = 1'b0;
      if (p) begin
        n_checks++;
        if (g !== e) begin n_errors++; $display("FAIL flush_pop: got %h want %h", g, e); end
      end
      n_checks++;
      if (bus.stall !== (k < 3) || bus.flush_done !== (k == 3)) begin
        n_errors++;
        $display("FAIL flush_seq%0d: got st=%b fd=%b, want st=%b fd=%b",
                 k, bus.stall, bus.flush_done, (k < 3), (k == 3));
      end
    end
    bus.flush_req = 1'b1;
    step(p, g, e);
    bus.flush_req = 1'b0;
    n_checks++;
    if (bus.flush_done !== 1'b1 || bus.stall !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_idle: got fd=%b st=%b, want fd=1 st=0", bus.flush_done, bus.stall);
    end
    step(p, g, e);
    n_checks++;
    if (bus.flush_done !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_idle_pulse: got fd=%b want 0", bus.flush_done);
    end
  endtask

  task automatic test_clear();
    bit p;
    item_t g, e;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom, 32'd4, 32'd4, i);
      step(p, g, e);
    end
    bus.clear = 1'b1;
    step(p, g, e);
    bus.clear = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    n_checks++;
    if (bus.occupancy !== 4'd0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.stall !== 1'b0 || bus.flush_done !== 1'b0) begin
      n_errors++;
      $display("FAIL clear: got occ=%0d v=%b ov=%b st=%b fd=%b, want all 0",
               bus.occupancy, bus.out_valid, bus.overflow, bus.stall, bus.flush_done);
    end
  endtask

  task automatic test_async_reset();
    bit p;
    item_t g, e;
    item_t want;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, 32'd8, 32'd8, i);
      step(p, g, e);
    end
    drive(1'b0, '0, '0, '0, '0);
    #2 arst_n_in = 1'b0;
    #1;
    q.delete();
    m_occ = 0;
    m_ovf = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.stall !== 1'b0 || bus.occupancy !== 4'd0) begin
      n_errors++;
      $display("FAIL arst: got v=%b st=%b occ=%0d, want 0 0 0", bus.out_valid, bus.stall, bus.occupancy);
    end
    #2 arst_n_in = 1'b1;
    @(posedge clk);
    #1;
    want = {32'hCAFE_F00D, 32'd11, 32'd12, 32'd13};
    drive(1'b1, want.d, want.x, want.y, want.ch);
    step(p, g, e);
    drive(1'b0, '0, '0, '0, '0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || {bus.out_data, bus.out_x, bus.out_y, bus.out_ch} !== want) begin
      n_errors++;
      $display("FAIL arst_push: got v=%b %h, want v=1 %h", bus.out_valid,
               {bus.out_data, bus.out_x, bus.out_y, bus.out_ch}, want);
    end
    bus.out_ready = 1'b1;
    step(p, g, e);
    n_checks++;
    if (!p || g !== e || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL arst_drain: got %h v=%b, want %h v=0", g, bus.out_valid, e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_occ    = 0;
    m_ovf    = 1'b0;
    test_reset();
    test_basic();
    test_full_overflow();
    test_back_to_back();
    test_flush();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
